// File: rtl/uprog_pkg.sv
// ============================================================================
// Module      : uprog_pkg
// Description : Shared types and encodings for the rvuprog microprogram
//               sequencer: micro-PC state codes, control-field encodings,
//               the packed control word and the supported opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uprog_pkg;

    // Micro-PC state codes; 12..15 are unused and decode as ERROR
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ERROR    = 4'd11
    } upc_state_t;

    // Unified-memory address select
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    // Supported major opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW         = 7'b0000011;
    localparam logic [6:0] OP_SW         = 7'b0100011;
    localparam logic [6:0] OP_R          = 7'b0110011;
    localparam logic [6:0] OP_I          = 7'b0010011;
    localparam logic [6:0] OP_JAL        = 7'b1101111;
    localparam logic [6:0] OP_BEQ        = 7'b1100011;

    // One microinstruction worth of datapath control
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_word_t;

    // Word presented while reset is held: FETCH selects, nothing enabled
    localparam ctrl_word_t CW_RESET = '{
        pc_update  : 1'b0,
        branch     : 1'b0,
        adr_src    : ADR_PC,
        ir_write   : 1'b0,
        mem_write  : 1'b0,
        reg_write  : 1'b0,
        result_src : RES_ALURESULT,
        alu_src_a  : SRCA_PC,
        alu_src_b  : SRCB_FOUR,
        alu_op     : ALUOP_ADD,
        illegal    : 1'b0
    };

endpackage

`default_nettype wire

// File: rtl/uprog_rom.sv
// ============================================================================
// Module      : uprog_rom
// Description : Combinational microcode ROM. Maps the micro-PC to its control
//               word and evaluates both opcode dispatch tables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uprog_rom
    import uprog_pkg::*;
#(
    parameter int UPC_W = 4
) (
    input  logic [UPC_W-1:0] i_upc,
    input  logic [6:0]       i_op,
    output ctrl_word_t       o_ctrl,
    output upc_state_t       o_disp1,
    output upc_state_t       o_disp2
);

    // DECODE dispatch: choose the first execution state from the opcode
    function automatic upc_state_t dispatch1(input logic [6:0] op);
        upc_state_t s;
        case (op)
            OP_LW, OP_SW: s = MEMADR;
            OP_R:         s = EXECR;
            OP_I:         s = EXECI;
            OP_JAL:       s = JAL;
            OP_BEQ:       s = BEQ;
            default:      s = ERROR;
        endcase
        return s;
    endfunction

    // MEMADR dispatch: split loads from stores
    function automatic upc_state_t dispatch2(input logic [6:0] op);
        upc_state_t s;
        case (op)
            OP_LW:   s = MEMREAD;
            OP_SW:   s = MEMWRITE;
            default: s = ERROR;
        endcase
        return s;
    endfunction

    ctrl_word_t w_word;

    // Microcode contents: one control word per micro-PC value
    always_comb begin
        w_word = '0;
        case (i_upc)
            UPC_W'(FETCH): begin
                w_word.ir_write   = 1'b1;
                w_word.pc_update  = 1'b1;
                w_word.alu_src_b  = SRCB_FOUR;
                w_word.result_src = RES_ALURESULT;
            end
            UPC_W'(DECODE): begin
                w_word.alu_src_a = SRCA_OLDPC;
                w_word.alu_src_b = SRCB_IMM;
            end
            UPC_W'(MEMADR): begin
                w_word.alu_src_a = SRCA_RD1;
                w_word.alu_src_b = SRCB_IMM;
            end
            UPC_W'(MEMREAD): begin
                w_word.adr_src = ADR_RESULT;
            end
            UPC_W'(MEMWB): begin
                w_word.result_src = RES_DATA;
                w_word.reg_write  = 1'b1;
            end
            UPC_W'(MEMWRITE): begin
                w_word.adr_src   = ADR_RESULT;
                w_word.mem_write = 1'b1;
            end
            UPC_W'(EXECR): begin
                w_word.alu_src_a = SRCA_RD1;
                w_word.alu_op    = ALUOP_FUNCT;
            end
            UPC_W'(EXECI): begin
                w_word.alu_src_a = SRCA_RD1;
                w_word.alu_src_b = SRCB_IMM;
                w_word.alu_op    = ALUOP_FUNCT;
            end
            UPC_W'(ALUWB): begin
                w_word.reg_write = 1'b1;
            end
            UPC_W'(JAL): begin
                w_word.alu_src_a = SRCA_OLDPC;
                w_word.alu_src_b = SRCB_FOUR;
                w_word.pc_update = 1'b1;
            end
            UPC_W'(BEQ): begin
                w_word.alu_src_a = SRCA_RD1;
                w_word.alu_op    = ALUOP_SUB;
                w_word.branch    = 1'b1;
            end
            default: begin
                // ERROR and every unused code: trap with all enables low
                w_word.illegal = 1'b1;
            end
        endcase
    end

    assign o_ctrl  = w_word;
    assign o_disp1 = dispatch1(i_op);
    assign o_disp2 = dispatch2(i_op);

endmodule

`default_nettype wire

// File: rtl/uprog_sequencer.sv
// ============================================================================
// Module      : uprog_sequencer
// Description : Microprogram sequencer for the rvuprog multicycle core. Holds
//               the micro-PC, selects the next address (sequential, dispatch
//               or trap) and drives the datapath control word with zero
//               latency from the micro-PC.
//               Optional build macro UPROG_WAIT_EN adds a mem_ready input that
//               stalls FETCH, MEMREAD and MEMWRITE until memory is ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uprog_sequencer
    import uprog_pkg::*;
#(
    parameter int UPC_W    = 4,
    parameter bit ERR_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             zero,
`ifdef UPROG_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [UPC_W-1:0] upc,
    output logic             illegal
);

    logic [UPC_W-1:0] r_upc;
    logic [UPC_W-1:0] w_upc_nxt;
    ctrl_word_t       w_rom;
    ctrl_word_t       w_word;
    upc_state_t       w_disp1;
    upc_state_t       w_disp2;
    logic             w_ready;
    logic             w_mem_state;
    logic             w_stall;

    uprog_rom #(
        .UPC_W   (UPC_W)
    ) u_rom (
        .i_upc   (r_upc),
        .i_op    (op),
        .o_ctrl  (w_rom),
        .o_disp1 (w_disp1),
        .o_disp2 (w_disp2)
    );

`ifdef UPROG_WAIT_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // Only the states that touch unified memory wait for it
    assign w_mem_state = (r_upc == UPC_W'(FETCH))   ||
                         (r_upc == UPC_W'(MEMREAD)) ||
                         (r_upc == UPC_W'(MEMWRITE));
    assign w_stall     = w_mem_state && !w_ready;

    // Next-address select: sequential successor, dispatch target or trap
    always_comb begin
        w_upc_nxt = UPC_W'(ERROR);
        case (r_upc)
            UPC_W'(FETCH):    w_upc_nxt = UPC_W'(DECODE);
            UPC_W'(DECODE):   w_upc_nxt = UPC_W'(w_disp1);
            UPC_W'(MEMADR):   w_upc_nxt = UPC_W'(w_disp2);
            UPC_W'(MEMREAD):  w_upc_nxt = UPC_W'(MEMWB);
            UPC_W'(MEMWB):    w_upc_nxt = UPC_W'(FETCH);
            UPC_W'(MEMWRITE): w_upc_nxt = UPC_W'(FETCH);
            UPC_W'(EXECR):    w_upc_nxt = UPC_W'(ALUWB);
            UPC_W'(EXECI):    w_upc_nxt = UPC_W'(ALUWB);
            UPC_W'(JAL):      w_upc_nxt = UPC_W'(ALUWB);
            UPC_W'(ALUWB):    w_upc_nxt = UPC_W'(FETCH);
            UPC_W'(BEQ):      w_upc_nxt = UPC_W'(FETCH);
            default:          w_upc_nxt = ERR_HOLD ? UPC_W'(ERROR) : UPC_W'(FETCH);
        endcase
        if (w_stall) begin
            w_upc_nxt = r_upc;
        end
    end

    // Micro-PC register with synchronous active-low reset to FETCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upc <= UPC_W'(FETCH);
        end else begin
            r_upc <= w_upc_nxt;
        end
    end

    // Gate the ROM word: stalls drop memory-side enables, reset drops all
    always_comb begin
        w_word = w_rom;
        if (w_stall) begin
            w_word.ir_write  = 1'b0;
            w_word.pc_update = 1'b0;
            w_word.branch    = 1'b0;
            w_word.mem_write = 1'b0;
        end
        if (!reset) begin
            w_word = CW_RESET;
        end
    end

    assign pc_write   = w_word.pc_update | (w_word.branch & zero);
    assign adr_src    = w_word.adr_src;
    assign ir_write   = w_word.ir_write;
    assign mem_write  = w_word.mem_write;
    assign reg_write  = w_word.reg_write;
    assign result_src = w_word.result_src;
    assign alu_src_a  = w_word.alu_src_a;
    assign alu_src_b  = w_word.alu_src_b;
    assign alu_op     = w_word.alu_op;
    assign illegal    = w_word.illegal;
    assign upc        = r_upc;

endmodule

`default_nettype wire

// File: tb/tb_uprog_sequencer.sv
// ============================================================================
// Module      : tb_uprog_sequencer
// Description : Scoreboard bench for uprog_sequencer. The driver pushes the
//               hand-derived expected micro-PC and control word for every
//               cycle; a negedge monitor pops and compares.
// Revision    : 1.1 - added end-of-run checks
// ============================================================================
`default_nettype none

module tb_uprog_sequencer;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] upc;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    // {upc, pc_write, adr_src, ir_write, mem_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, illegal}
    logic [17:0] sb_q[$];

    uprog_sequencer #(
        .UPC_W      (4),
        .ERR_HOLD   (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
`ifdef UPROG_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .upc        (upc),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, straight from the state table
    function automatic logic [17:0] exp_word(input int st, input bit rn,
                                             input bit z, input bit rdy);
        logic [3:0] s;
        logic       pcw, adr, irw, mw, rw, ill;
        logic [1:0] res, sa, sb, ao;
        s = st[3:0];
        {pcw, adr, irw, mw, rw, ill} = '0;
        {res, sa, sb, ao} = '0;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1; end
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            8:  begin rw = 1; end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            10: begin sa = 2'b10; ao = 2'b01; pcw = z; end
            default: ill = 1;
        endcase
        if (!rdy && (st == 0 || st == 3 || st == 5)) begin
            irw = 0; pcw = 0; mw = 0;
        end
        if (!rn) begin
            {pcw, adr, irw, mw, rw, ill} = '0;
            res = 2'b10; sa = 2'b00; sb = 2'b10; ao = 2'b00;
        end
        return {s, pcw, adr, irw, mw, rw, res, sa, sb, ao, ill};
    endfunction

    // One cycle: drive inputs, queue the expectation, advance past the edge
    task automatic cyc(input int st, input bit rn, input logic [6:0] o,
                       input bit z, input bit rdy);
        reset     = rn;
        op        = o;
        zero      = z;
        mem_ready = rdy;
        sb_q.push_back(exp_word(st, rn, z, rdy));
        @(posedge clk);
        #1;
    endtask

    // One whole instruction with its hand-written micro-PC sequence
    task automatic run_instr(input logic [6:0] o, input bit z, input int n,
                             input int s0, input int s1, input int s2,
                             input int s3, input int s4);
        int seq[5];
        seq = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++) begin
            cyc(seq[i], 1'b1, o, z, 1'b1);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = {upc, pc_write, adr_src, ir_write, mem_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, illegal};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL ctl[%0d] t=%0t: got upc=%0d word=%b, required upc=%0d word=%b",
                         total, $time, g[17:14], g[13:0], e[17:14], e[13:0]);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        op        = 7'h03;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // second reset cycle: upc already FETCH, enables forced off
        cyc(0, 1'b0, 7'h03, 1'b0, 1'b1);

        run_instr(7'h03, 1'b0, 5, 0, 1, 2, 3, 4);   // lw
        run_instr(7'h23, 1'b0, 4, 0, 1, 2, 5, 0);   // sw
        run_instr(7'h63, 1'b1, 3, 0, 1, 10, 0, 0);  // beq taken
        run_instr(7'h63, 1'b0, 3, 0, 1, 10, 0, 0);  // beq not taken
        run_instr(7'h6F, 1'b1, 4, 0, 1, 9, 8, 0);   // jal
        run_instr(7'h33, 1'b0, 4, 0, 1, 6, 8, 0);   // R-type
        run_instr(7'h13, 1'b1, 4, 0, 1, 7, 8, 0);   // I-type

        // illegal opcode traps and stays trapped
        cyc(0, 1'b1, 7'h7F, 1'b0, 1'b1);
        cyc(1, 1'b1, 7'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(11, 1'b1, 7'h7F, i[0], 1'b1);
        end
        cyc(11, 1'b0, 7'h03, 1'b0, 1'b1);           // reset while trapped
        run_instr(7'h03, 1'b0, 5, 0, 1, 2, 3, 4);

`ifdef UPROG_WAIT_EN
        // FETCH stall, then a MEMREAD stall abandoned by reset
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b1, 7'h03, 1'b0, 1'b0);
        end
        cyc(0, 1'b1, 7'h03, 1'b0, 1'b1);
        cyc(1, 1'b1, 7'h03, 1'b0, 1'b1);
        cyc(2, 1'b1, 7'h03, 1'b0, 1'b1);
        cyc(3, 1'b1, 7'h03, 1'b0, 1'b0);
        cyc(3, 1'b0, 7'h03, 1'b0, 1'b0);
        // store with a one-cycle MEMWRITE stall
        cyc(0, 1'b1, 7'h23, 1'b0, 1'b1);
        cyc(1, 1'b1, 7'h23, 1'b0, 1'b1);
        cyc(2, 1'b1, 7'h23, 1'b0, 1'b1);
        cyc(5, 1'b1, 7'h23, 1'b0, 1'b0);
        cyc(5, 1'b1, 7'h23, 1'b0, 1'b1);
`endif

        cyc(0, 1'b1, 7'h03, 1'b0, 1'b1);

        // after the final FETCH edge the sequencer sits in DECODE
        if (upc !== 4'd1) begin
            bad++;
            $display("FAIL end upc: got %0d, required 1", upc);
        end
        if (ir_write !== 1'b0) begin
            bad++;
            $display("FAIL end ir_write: got %b, required 0", ir_write);
        end
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL end illegal: got %b, required 0", illegal);
        end
        if (alu_src_a !== 2'b01 || alu_src_b !== 2'b01) begin
            bad++;
            $display("FAIL end srcs: got a=%b b=%b, required a=01 b=01",
                     alu_src_a, alu_src_b);
        end
        if (total == 0) begin
            bad++;
            $display("FAIL end total: got 0 checks, required more than 0");
        end
        if (bad != 0) begin
            $display("FAIL summary: got %0d mismatches, required 0", bad);
        end else begin
            $display("PASS");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
